fb_pixel_sink: RTL and testbench
================================

FB_PIXEL_SINK -- requirements
Module: fb_pixel_sink

Interface
REQ-001 Parameter RESOLUTION_H, default 1280: active pixels per line; hpos values at or above it are out of range.
REQ-002 Parameter RESOLUTION_V, default 960: active lines; vpos values at or above it are out of range.
REQ-003 Parameter SCALE_SHIFT, default 4: coordinate downscale, cell = pos >> SCALE_SHIFT (80x60 cells at defaults).
REQ-004 Parameter X_WIRE_WIDTH, default 11; Y_WIRE_WIDTH, default 10: coordinate widths.
REQ-005 Parameter ADDR_WIDTH, default 12: RAM address width; RAM word is 6 bits = 2 pixels x 3-bit RGB.
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 fifo_empty  in  1  pixel FIFO holds no entry.
REQ-009 fifo_rd  out  1  pop strobe; FIFO data is valid the cycle after the strobe.
REQ-010 fifo_hpos  in  X_WIRE_WIDTH; fifo_vpos  in  Y_WIRE_WIDTH; fifo_rgb  in  3  popped pixel record.
REQ-011 ram_addr  out  ADDR_WIDTH; ram_we  out  1; ram_wdata  out  6  framebuffer write port.
REQ-012 ram_rdata  in  6  framebuffer read data, valid one cycle after ram_addr is presented.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 wr_count  out  16  pixels committed to RAM, saturating at 0xFFFF.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, READ, WRITE; encoding is free.
REQ-016 IDLE: if fifo_empty=0, assert fifo_rd for exactly one cycle and go to FETCH; otherwise stay, fifo_rd=0.
REQ-017 FETCH: capture fifo_hpos/vpos/rgb; compute cx=hpos>>SCALE_SHIFT, cy=vpos>>SCALE_SHIFT, idx=cy*(RESOLUTION_H>>SCALE_SHIFT)+cx, drive ram_addr=idx>>1, latch lane=idx[0]; go to READ.
REQ-018 FETCH with hpos>=RESOLUTION_H or vpos>=RESOLUTION_V SHALL drop the record (no RAM access) and return to IDLE.
REQ-019 READ: hold ram_addr; go to WRITE.
REQ-020 WRITE: ram_we=1 for one cycle; ram_wdata = ram_rdata with bits [2:0] replaced by rgb when lane=0, bits [5:3] when lane=1; increment wr_count; return to IDLE.
REQ-021 ram_we SHALL be high only in WRITE; fifo_rd only in IDLE; no pop while a record is in flight.
REQ-022 Throughput SHALL be one in-range pixel per 4 cycles, one dropped pixel per 2 cycles, with back-to-back pops when the FIFO stays non-empty.
REQ-023 Index arithmetic SHALL be full-width with no truncation before the >>1 (max idx 4799 at defaults).

Reset
REQ-024 While rst=0: state=IDLE, fifo_rd=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0, wr_count=0.
REQ-025 Reset asserted mid-operation SHALL abort without a write; a popped record is lost.
REQ-026 After rst rises, the first pop SHALL occur no earlier than the first clk edge with fifo_empty=0.

Configuration
REQ-027 Macro FB_SINK_DROP_CNT_EN defined: add output drop_count (16 bits, reset 0, saturating) incremented once per record dropped under REQ-018.
REQ-028 Macro undefined: no drop_count port or logic; drop behaviour is otherwise identical.

Verification
REQ-029 hpos=0, vpos=0, rgb=3'b101, RAM word 0 = 6'b000000 -> ram_addr=0, ram_we in cycle 4 after pop, wdata=6'b000101, wr_count=1.
REQ-030 hpos=16, vpos=0, rgb=3'b011, RAM word 0 = 6'b000101 -> lane 1, wdata=6'b011101.
REQ-031 hpos=1279, vpos=959, rgb=3'b111 -> idx=4799, ram_addr=2399, upper lane written.
REQ-032 hpos=1280, vpos=10 -> no ram_we, wr_count unchanged, state IDLE 2 cycles after pop; drop_count=1 with FB_SINK_DROP_CNT_EN.
REQ-033 FIFO with 5 valid entries held non-empty -> 5 pops spaced exactly 4 cycles, wr_count=5.
REQ-034 rst=0 asserted in READ -> ram_we never asserted, all outputs at reset values immediately, normal operation on next record.

Source files
------------

// File: rtl/fb_pixel_sink.sv
// Framebuffer pixel sink: pops (hpos, vpos, rgb) records from a FIFO and read-modify-writes one
// 3-bit lane of a 6-bit RAM word per pixel. Optional FB_SINK_DROP_CNT_EN adds a drop_count output.
module fb_pixel_sink #(
  parameter int unsigned RESOLUTION_H = 1280,
  parameter int unsigned RESOLUTION_V = 960,
  parameter int unsigned SCALE_SHIFT  = 4,
  parameter int unsigned X_WIRE_WIDTH = 11,
  parameter int unsigned Y_WIRE_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH   = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  output logic                    fifo_rd,
  input  logic [X_WIRE_WIDTH-1:0] fifo_hpos,
  input  logic [Y_WIRE_WIDTH-1:0] fifo_vpos,
  input  logic [2:0]              fifo_rgb,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic                    ram_we,
  output logic [5:0]              ram_wdata,
  input  logic [5:0]              ram_rdata,
  output logic                    busy,
  output logic [15:0]             wr_count
`ifdef FB_SINK_DROP_CNT_EN
  ,
  output logic [15:0]             drop_count
`endif
);

  localparam int unsigned CELLS_H = RESOLUTION_H >> SCALE_SHIFT;
  localparam int unsigned IDX_W   = X_WIRE_WIDTH + Y_WIRE_WIDTH;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic                    armed;
  logic                    in_range_c;
  logic [X_WIRE_WIDTH-1:0] cx_c;
  logic [Y_WIRE_WIDTH-1:0] cy_c;
  logic [IDX_W-1:0]        idx_c;
  logic [ADDR_WIDTH-1:0]   addr_c;
  logic [5:0]              merge_c;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    lane_q;
  logic [2:0]              rgb_q;

  logic                    capture_c;
  logic                    drop_c;
  logic                    load_wdata_c;
  logic                    commit_c;

  // Cell index from the popped coordinates, kept full width until the word select
  always_comb begin
    cx_c       = fifo_hpos >> SCALE_SHIFT;
    cy_c       = fifo_vpos >> SCALE_SHIFT;
    idx_c      = IDX_W'(cy_c) * IDX_W'(CELLS_H) + IDX_W'(cx_c);
    addr_c     = ADDR_WIDTH'(idx_c >> 1);
    in_range_c = (32'(fifo_hpos) < RESOLUTION_H) && (32'(fifo_vpos) < RESOLUTION_V);
  end

  // Lane 0 owns bits [2:0], lane 1 owns bits [5:3]
  always_comb begin
    merge_c = lane_q ? {rgb_q, ram_rdata[2:0]} : {ram_rdata[5:3], rgb_q};
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (armed && !fifo_empty) state_next = FETCH;
      FETCH:   state_next = in_range_c ? READ : IDLE;
      READ:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pop strobe and FETCH-cycle address are decoded here so the FIFO data and the
  // RAM read data each arrive exactly one cycle later.
  always_comb begin
    fifo_rd      = 1'b0;
    ram_addr     = addr_q;
    capture_c    = 1'b0;
    drop_c       = 1'b0;
    load_wdata_c = 1'b0;
    commit_c     = 1'b0;
    case (state)
      IDLE: fifo_rd = armed & ~fifo_empty;
      FETCH: begin
        if (in_range_c) begin
          capture_c = 1'b1;
          ram_addr  = addr_c;
        end else begin
          drop_c = 1'b1;
        end
      end
      READ:    load_wdata_c = 1'b1;
      WRITE:   commit_c     = 1'b1;
      default: ;
    endcase
  end

  // Datapath and registered outputs; armed holds off popping until the first edge out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed     <= 1'b0;
      busy      <= 1'b0;
      ram_we    <= 1'b0;
      ram_wdata <= 6'd0;
      wr_count  <= 16'd0;
      addr_q    <= '0;
      lane_q    <= 1'b0;
      rgb_q     <= 3'd0;
    end else begin
      armed  <= 1'b1;
      busy   <= (state_next != IDLE);
      ram_we <= (state_next == WRITE);
      if (capture_c) begin
        addr_q <= addr_c;
        lane_q <= idx_c[0];
        rgb_q  <= fifo_rgb;
      end
      if (load_wdata_c) begin
        ram_wdata <= merge_c;
      end
      if (commit_c && (wr_count != {CNT_W{1'b1}})) begin
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

`ifdef FB_SINK_DROP_CNT_EN
  // Saturating count of out-of-range records
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count <= 16'd0;
    end else if (drop_c && (drop_count != {CNT_W{1'b1}})) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop_c;
`endif

endmodule

// File: tb/tb_fb_pixel_sink.sv
// Directed bench for fb_pixel_sink: behavioural FIFO and RAM models, table of single-pixel
// vectors with exact cycle checks, plus burst-throughput and mid-operation reset sequences.
module tb_fb_pixel_sink;

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic [2:0]  rgb;
  } rec_t;

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic [2:0]  rgb;
    logic        in_range;
    logic [11:0] addr;
    logic [5:0]  pre;
    logic [5:0]  wdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [10:0] fifo_hpos = '0;
  logic [9:0]  fifo_vpos = '0;
  logic [2:0]  fifo_rgb  = '0;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [5:0]  ram_wdata;
  logic [5:0]  ram_rdata = '0;
  logic        busy;
  logic [15:0] wr_count;
`ifdef FB_SINK_DROP_CNT_EN
  logic [15:0] drop_count;
  int          exp_drop = 0;
`endif

  fb_pixel_sink dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_hpos  (fifo_hpos),
    .fifo_vpos  (fifo_vpos),
    .fifo_rgb   (fifo_rgb),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .busy       (busy),
    .wr_count   (wr_count)
`ifdef FB_SINK_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: tail advanced by the stimulus, head by the pop strobe
  rec_t fq [32];
  int   head = 0;
  int   tail = 0;
  assign fifo_empty = (head == tail);

  // RAM model and activity monitor
  logic [5:0]  mem [4096];
  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [5:0]  pre_data = '0;
  int          cyc = 0;
  int          we_cnt = 0;
  int          pop_cnt = 0;
  int          proto_err = 0;
  int          pop_cyc [64];
  logic [11:0] last_addr = '0;
  logic [5:0]  last_data = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ram_rdata <= mem[ram_addr];
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_we) begin
      we_cnt    <= we_cnt + 1;
      last_addr <= ram_addr;
      last_data <= ram_wdata;
    end
    if (fifo_rd && !fifo_empty) begin
      fifo_hpos <= fq[head % 32].h;
      fifo_vpos <= fq[head % 32].v;
      fifo_rgb  <= fq[head % 32].rgb;
      head      <= head + 1;
      pop_cyc[pop_cnt % 64] <= cyc;
      pop_cnt   <= pop_cnt + 1;
    end
    if (fifo_rd && (fifo_empty || busy)) proto_err <= proto_err + 1;
  end

  int n_vec = 0;
  int n_err = 0;
  int exp_wr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [10:0] h, input logic [9:0] v, input logic [2:0] rgb);
    fq[tail % 32] = '{h, v, rgb};
    tail++;
  endtask

  task automatic preload(input logic [11:0] a, input logic [5:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic wait_quiet(input int max_cyc, input string name);
    int k = 0;
    while ((busy || head != tail) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(k < max_cyc), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs [11];

  initial begin
    int we0, wr0, pc0;

    vecs[0]  = '{11'd0,    10'd0,    3'b101, 1'b1, 12'd0,    6'b000000, 6'b000101};
    vecs[1]  = '{11'd16,   10'd0,    3'b011, 1'b1, 12'd0,    6'b000101, 6'b011101};
    vecs[2]  = '{11'd1279, 10'd959,  3'b111, 1'b1, 12'd2399, 6'b010010, 6'b111010};
    vecs[3]  = '{11'd1280, 10'd10,   3'b001, 1'b0, 12'd0,    6'b000000, 6'b000000};
    vecs[4]  = '{11'd32,   10'd16,   3'b110, 1'b1, 12'd41,   6'b101011, 6'b101110};
    vecs[5]  = '{11'd48,   10'd16,   3'b001, 1'b1, 12'd41,   6'b101011, 6'b001011};
    vecs[6]  = '{11'd0,    10'd960,  3'b111, 1'b0, 12'd0,    6'b000000, 6'b000000};
    vecs[7]  = '{11'd15,   10'd15,   3'b010, 1'b1, 12'd0,    6'b111111, 6'b111010};
    vecs[8]  = '{11'd640,  10'd480,  3'b100, 1'b1, 12'd1220, 6'b000000, 6'b000100};
    vecs[9]  = '{11'd1279, 10'd0,    3'b001, 1'b1, 12'd39,   6'b000111, 6'b001111};
    vecs[10] = '{11'd2047, 10'd1023, 3'b010, 1'b0, 12'd0,    6'b000000, 6'b000000};

    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_fifo_rd",   32'(fifo_rd),   32'd0);
    chk("rst_ram_we",    32'(ram_we),    32'd0);
    chk("rst_ram_addr",  32'(ram_addr),  32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_wr_count",  32'(wr_count),  32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single-pixel vectors with exact per-cycle expectations
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].in_range) preload(vecs[i].addr, vecs[i].pre);
      @(negedge clk);
      we0 = we_cnt;
      push(vecs[i].h, vecs[i].v, vecs[i].rgb);
      #1;
      chk($sformatf("v%0d_pop", i), 32'(fifo_rd), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_fetch_busy", i), 32'(busy), 32'd1);
      if (vecs[i].in_range) chk($sformatf("v%0d_fetch_addr", i), 32'(ram_addr), 32'(vecs[i].addr));
      @(negedge clk);
      if (!vecs[i].in_range) begin
`ifdef FB_SINK_DROP_CNT_EN
        exp_drop++;
        chk($sformatf("v%0d_drop_count", i), 32'(drop_count), 32'(exp_drop));
`endif
        chk($sformatf("v%0d_drop_idle", i), 32'(busy), 32'd0);
        chk($sformatf("v%0d_drop_no_we", i), 32'(we_cnt - we0), 32'd0);
        chk($sformatf("v%0d_drop_wr_count", i), 32'(wr_count), 32'(exp_wr));
      end else begin
        chk($sformatf("v%0d_read_we", i), 32'(ram_we), 32'd0);
        chk($sformatf("v%0d_read_addr", i), 32'(ram_addr), 32'(vecs[i].addr));
        @(negedge clk);
        chk($sformatf("v%0d_write_we", i), 32'(ram_we), 32'd1);
        chk($sformatf("v%0d_write_addr", i), 32'(ram_addr), 32'(vecs[i].addr));
        chk($sformatf("v%0d_wdata", i), 32'(ram_wdata), 32'(vecs[i].wdata));
        @(negedge clk);
        exp_wr++;
        chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
        chk($sformatf("v%0d_wr_count", i), 32'(wr_count), 32'(exp_wr));
        chk($sformatf("v%0d_one_write", i), 32'(we_cnt - we0), 32'd1);
      end
    end

    // Five records queued at once: pops every 4 cycles
    @(negedge clk);
    pc0 = pop_cnt; wr0 = exp_wr; we0 = we_cnt;
    for (int k = 0; k < 5; k++) push(11'(16 * k), 10'd32, 3'(k));
    wait_quiet(60, "burst_timeout");
    exp_wr = wr0 + 5;
    chk("burst_pops", 32'(pop_cnt - pc0), 32'd5);
    for (int k = 0; k < 4; k++)
      chk($sformatf("burst_gap%0d", k), 32'(pop_cyc[(pc0 + k + 1) % 64] - pop_cyc[(pc0 + k) % 64]), 32'd4);
    chk("burst_wr_count", 32'(wr_count), 32'(exp_wr));
    chk("burst_writes", 32'(we_cnt - we0), 32'd5);

    // In-range, dropped, in-range: gaps of 4 then 2
    @(negedge clk);
    pc0 = pop_cnt; wr0 = exp_wr;
    push(11'd0, 10'd100, 3'b001);
    push(11'd1300, 10'd100, 3'b010);
    push(11'd32, 10'd100, 3'b011);
    wait_quiet(40, "mixed_timeout");
    exp_wr = wr0 + 2;
`ifdef FB_SINK_DROP_CNT_EN
    exp_drop++;
    chk("mixed_drop_count", 32'(drop_count), 32'(exp_drop));
`endif
    chk("mixed_pops", 32'(pop_cnt - pc0), 32'd3);
    chk("mixed_gap_in", 32'(pop_cyc[(pc0 + 1) % 64] - pop_cyc[pc0 % 64]), 32'd4);
    chk("mixed_gap_drop", 32'(pop_cyc[(pc0 + 2) % 64] - pop_cyc[(pc0 + 1) % 64]), 32'd2);
    chk("mixed_wr_count", 32'(wr_count), 32'(exp_wr));

    // Reset while in READ: no write, record lost, next record processed normally
    preload(12'd2, 6'b000000);
    @(negedge clk);
    pc0 = pop_cnt; we0 = we_cnt;
    push(11'd64, 10'd64, 3'b110);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    exp_wr = 0;
    chk("rstmid_fifo_rd",   32'(fifo_rd),   32'd0);
    chk("rstmid_ram_we",    32'(ram_we),    32'd0);
    chk("rstmid_ram_addr",  32'(ram_addr),  32'd0);
    chk("rstmid_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rstmid_busy",      32'(busy),      32'd0);
    chk("rstmid_wr_count",  32'(wr_count),  32'd0);
`ifdef FB_SINK_DROP_CNT_EN
    exp_drop = 0;
    chk("rstmid_drop_count", 32'(drop_count), 32'd0);
`endif
    push(11'd80, 10'd0, 3'b011);
    repeat (3) @(negedge clk);
    chk("rstmid_no_pop", 32'(pop_cnt - pc0), 32'd1);
    chk("rstmid_no_write", 32'(we_cnt - we0), 32'd0);
    rst = 1'b1;
    wait_quiet(20, "rstmid_timeout");
    exp_wr = 1;
    chk("rstmid_after_wr_count", 32'(wr_count), 32'(exp_wr));
    chk("rstmid_after_writes", 32'(we_cnt - we0), 32'd1);
    chk("rstmid_after_addr", 32'(last_addr), 32'd2);
    chk("rstmid_after_data", 32'(last_data), 32'(6'b011000));

    chk("protocol_errors", 32'(proto_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
